// File: rtl/neuron_train_sched.sv
// Training-phase scheduler: walks SAMPLES samples for a latched number of epochs,
// driving the neuron's fp/bp windows. Optional loss accumulator: NEURON_TRAIN_LOSS_ACC_EN.
module neuron_train_sched #(
    parameter int BITS      = 16,
    parameter int SAMPLES   = 4,
    parameter int IDX_W     = 2,
    parameter int FP_CYCLES = 8,
    parameter int BP_CYCLES = 6,
    parameter int EPOCH_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               infer_only,
    input  logic [EPOCH_W-1:0] epochs,
    input  logic [BITS-1:0]    dz_in,
    output logic               fp,
    output logic               bp,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               y_valid,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               busy,
    output logic               done,
    output logic [BITS-1:0]    epoch_loss,
    output logic               loss_valid
);

    typedef enum logic [2:0] {IDLE, LOAD, FWD, GAP, BWD, NEXT, FIN} state_t;

    localparam int MAX_CYC = (FP_CYCLES > BP_CYCLES) ? FP_CYCLES : BP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx_n;
    logic [EPOCH_W-1:0] ecnt_n;
    logic [EPOCH_W-1:0] epochs_q, epochs_n;
    logic               infer_q, infer_n;
    logic               fp_n, bp_n, yv_n, done_n;
    logic               start_acc, epoch_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sample_idx <= '0;
            epoch_cnt  <= '0;
            epochs_q   <= '0;
            infer_q    <= 1'b0;
            fp         <= 1'b0;
            bp         <= 1'b0;
            y_valid    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sample_idx <= idx_n;
            epoch_cnt  <= ecnt_n;
            epochs_q   <= epochs_n;
            infer_q    <= infer_n;
            fp         <= fp_n;
            bp         <= bp_n;
            y_valid    <= yv_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = sample_idx;
        ecnt_n    = epoch_cnt;
        epochs_n  = epochs_q;
        infer_n   = infer_q;
        start_acc = 1'b0;
        epoch_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    epochs_n  = epochs;
                    infer_n   = infer_only;
                    idx_n     = '0;
                    ecnt_n    = '0;
                    state_n   = (epochs == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                cnt_n   = '0;
                state_n = FWD;
            end
            FWD: begin
                if (cnt == CNT_W'(FP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = infer_q ? NEXT : GAP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                cnt_n   = '0;
                state_n = BWD;
            end
            BWD: begin
                if (cnt == CNT_W'(BP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = NEXT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            NEXT: begin
                if (sample_idx < IDX_W'(SAMPLES - 1)) begin
                    idx_n   = sample_idx + IDX_W'(1);
                    state_n = LOAD;
                end else begin
                    idx_n     = '0;
                    ecnt_n    = epoch_cnt + EPOCH_W'(1);
                    epoch_end = 1'b1;
                    state_n   = (epoch_cnt + EPOCH_W'(1) == epochs_q) ? FIN : LOAD;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Abort wins over every transition and freezes the sample/epoch counters.
        if (abort && (state != IDLE)) begin
            state_n   = IDLE;
            cnt_n     = '0;
            idx_n     = sample_idx;
            ecnt_n    = epoch_cnt;
            epoch_end = 1'b0;
        end

        fp_n   = (state_n == FWD);
        bp_n   = (state_n == BWD);
        done_n = (state_n == FIN);
        yv_n   = (state_n == FWD) && (cnt_n == CNT_W'(FP_CYCLES - 1));
    end

    assign busy = (state != IDLE);

`ifdef NEURON_TRAIN_LOSS_ACC_EN
    logic [BITS-1:0] acc, loss_q, dz_abs, acc_sum;
    logic [BITS:0]   sum_wide;
    logic            lv_q;

    // Most negative input has no positive twin, so it clamps to the largest positive.
    always_comb begin
        dz_abs = dz_in;
        if (dz_in[BITS-1]) begin
            if (dz_in == {1'b1, {(BITS-1){1'b0}}}) dz_abs = {1'b0, {(BITS-1){1'b1}}};
            else                                   dz_abs = -dz_in;
        end
        sum_wide = {1'b0, acc} + {1'b0, dz_abs};
        acc_sum  = sum_wide[BITS] ? '1 : sum_wide[BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            loss_q <= '0;
            lv_q   <= 1'b0;
        end else begin
            lv_q <= 1'b0;
            if (start_acc) begin
                acc <= '0;
            end else if ((state == NEXT) && !abort) begin
                if (epoch_end) begin
                    loss_q <= acc_sum;
                    lv_q   <= 1'b1;
                    acc    <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign epoch_loss = loss_q;
    assign loss_valid = lv_q;
`else
    logic unused_loss;
    assign unused_loss = ^{dz_in, start_acc, epoch_end};
    assign epoch_loss  = '0;
    assign loss_valid  = 1'b0;
`endif

endmodule
